mini_alu: RTL and testbench
===========================

// Module: mini_alu
// PURPOSE
//  Minimal 8-bit ROM-programmed processor for the lab board: fetches 16-bit instructions
//  from an internal program ROM, executes one per cycle on an 8x8-bit register file,
//  drives 8 LEDs, and writes 4-bit nibbles to an external LCD controller through a
//  writeEN/response handshake. Top-level block; the LCD controller sits outside it.
// PARAMETERS
//  PC_W    6   program counter width; ROM depth = 2**PC_W words
//  DATA_W  8   register/ALU width (fixed at 8 for this design)
// PORTS
//  Clock          in   1  system clock, all state changes on posedge
//  Reset          in   1  one clock; reset is synchronous and active-low
//  oLed           out  8  LED register, written by LED instruction
//  iLCD_response  in   1  LCD controller ack/busy level (1 = nibble accepted / busy)
//  oLCD_data      out  4  nibble presented to LCD controller
//  oLCD_reset     out  1  LCD controller reset, written by LCDRST instruction
//  oLCD_writeEN   out  1  write strobe, held high until iLCD_response==1
// BEHAVIOUR
//  - Reset (Reset==0 at posedge): PC=0, R0..R7=0, oLed=0x00, oLCD_data=0,
//    oLCD_writeEN=0, oLCD_reset=1, state=EXEC. Reset overrides everything, incl. WAIT.
//  - Fetch: ROM read combinational at PC; result of instr at PC=k registered at the
//    edge ending cycle k. Default PC update PC+1, wraps 2**PC_W-1 -> 0.
//  - Format: op[15:12] d[11:9] a[8:6] b[5:3]; imm[7:0]; tgt[PC_W-1:0].
//  - Opcodes: 0 NOP; 1 STO Rd=imm; 2 ADD Rd=Ra+Rb; 3 SUB Rd=Ra-Rb; 4 AND; 5 OR;
//    6 LED oLed=Rd; 7 JMP PC=tgt; 8 BLE if Rd<=Ra (unsigned) PC=tgt else PC+1;
//    9 LCD send Rd[3:0]; A LCDRST oLCD_reset=imm[0]; B-F behave as NOP.
//  - Arithmetic modulo 256, no flags; Rd may equal Ra/Rb (read old values).
//  - States: EXEC, WAIT.
//    EXEC + LCD, iLCD_response==1: stall (PC held, nothing written) until it is 0.
//    EXEC + LCD, iLCD_response==0: oLCD_data<=Rd[3:0], oLCD_writeEN<=1, PC held, ->WAIT.
//    WAIT: response==0 -> hold all; response==1 -> oLCD_writeEN<=0, PC<=PC+1, ->EXEC.
//  - oLCD_data holds last sent nibble until next LCD send. All outputs registered.
//  - Default ROM program:
//    0 STO R1,0x05 | 1 STO R2,0x03 | 2 ADD R3,R1,R2 | 3 LED R3 | 4 LCD R1
//    5 LCDRST 0 | 6 SUB R4,R1,R2 | 7 LED R4 | 8 JMP 8 (halt loop)
// TESTING
//  1 Hold Reset=0 5 cycles -> all outputs at reset values, PC=0; release -> PC=1 next edge.
//  2 Run default ROM, iLCD_response=0 -> oLed=0x08 after PC=3 retires; at PC=4
//    oLCD_writeEN=1, oLCD_data=0x5, PC stays 4 while response=0.
//  3 Raise iLCD_response 1 cycle -> oLCD_writeEN=0 next edge, PC=5; then oLCD_reset=0.
//  4 Continue -> oLed=0x02, PC loops at 8 indefinitely, no further writeEN pulses.
//  5 ROM: STO R1,0x01; STO R2,0x02; SUB R3,R1,R2; LED R3 -> oLed=0xFF (wrap);
//    BLE R1,R2->tgt jumps (1<=2); BLE R2,R1 falls through.
//  6 Response held 1 when LCD reached -> stall, writeEN stays 0; drop to 0 -> writeEN=1;
//    Reset=0 during WAIT -> writeEN=0, PC=0 next edge.

Source files
------------

// File: rtl/mini_alu.sv
// mini_alu: 8-bit ROM-programmed processor, one instruction per cycle, with LED
// register and a 4-bit LCD write port using a writeEN/response handshake.
module mini_alu #(
  parameter int unsigned               PC_W            = 6,
  parameter int unsigned               DATA_W          = 8,
  parameter bit                        USE_DEFAULT_ROM = 1'b1,
  parameter logic [(2**PC_W)*16-1:0]   ROM_IMAGE       = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [7:0]        oLed,
  input  logic              iLCD_response,
  output logic [3:0]        oLCD_data,
  output logic              oLCD_reset,
  output logic              oLCD_writeEN
);

  typedef enum logic {EXEC, WAIT} state_e;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_STO    = 4'h1,
    OP_ADD    = 4'h2,
    OP_SUB    = 4'h3,
    OP_AND    = 4'h4,
    OP_OR     = 4'h5,
    OP_LED    = 4'h6,
    OP_JMP    = 4'h7,
    OP_BLE    = 4'h8,
    OP_LCD    = 4'h9,
    OP_LCDRST = 4'hA
  } op_e;

  state_e              state_q;
  logic [PC_W-1:0]     pc_q;
  logic [DATA_W-1:0]   rf_q [8];
  logic [7:0]          led_q;
  logic [3:0]          lcd_data_q;
  logic                lcd_rst_q;
  logic                lcd_we_q;

  logic [15:0]         instr;
  op_e                 op;
  logic [2:0]          d_idx, a_idx, b_idx;
  logic [DATA_W-1:0]   rd_val, ra_val, rb_val, imm, alu_d;
  logic [PC_W-1:0]     tgt, pc_inc;

  function automatic logic [15:0] default_rom(input logic [PC_W-1:0] addr);
    int unsigned idx;
    idx = int'(addr);
    case (idx)
      0:       return 16'h1205;  // STO R1,0x05
      1:       return 16'h1403;  // STO R2,0x03
      2:       return 16'h2650;  // ADD R3,R1,R2
      3:       return 16'h6600;  // LED R3
      4:       return 16'h9200;  // LCD R1
      5:       return 16'hA000;  // LCDRST 0
      6:       return 16'h3850;  // SUB R4,R1,R2
      7:       return 16'h6800;  // LED R4
      8:       return 16'h7008;  // JMP 8
      default: return 16'h0000;
    endcase
  endfunction

  always_comb begin
    instr  = USE_DEFAULT_ROM ? default_rom(pc_q) : ROM_IMAGE[{pc_q, 4'b0000} +: 16];
    op     = op_e'(instr[15:12]);
    d_idx  = instr[11:9];
    a_idx  = instr[8:6];
    b_idx  = instr[5:3];
    imm    = instr[DATA_W-1:0];
    tgt    = instr[PC_W-1:0];
    rd_val = rf_q[d_idx];
    ra_val = rf_q[a_idx];
    rb_val = rf_q[b_idx];
    pc_inc = pc_q + PC_W'(1);
    alu_d  = '0;
    case (op)
      OP_ADD:  alu_d = ra_val + rb_val;
      OP_SUB:  alu_d = ra_val - rb_val;
      OP_AND:  alu_d = ra_val & rb_val;
      OP_OR:   alu_d = ra_val | rb_val;
      default: alu_d = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q    <= EXEC;
      pc_q       <= '0;
      for (int unsigned i = 0; i < 8; i++) rf_q[i] <= '0;
      led_q      <= '0;
      lcd_data_q <= '0;
      lcd_rst_q  <= 1'b1;
      lcd_we_q   <= 1'b0;
    end else begin
      case (state_q)
        EXEC: begin
          case (op)
            OP_STO: begin
              rf_q[d_idx] <= imm;
              pc_q        <= pc_inc;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              rf_q[d_idx] <= alu_d;
              pc_q        <= pc_inc;
            end
            OP_LED: begin
              led_q <= rd_val;
              pc_q  <= pc_inc;
            end
            OP_JMP: pc_q <= tgt;
            OP_BLE: pc_q <= (rd_val <= ra_val) ? tgt : pc_inc;
            OP_LCD: begin
              // PC stays on the LCD instruction both while the controller is busy and
              // while waiting for its ack; it only advances on leaving WAIT.
              if (!iLCD_response) begin
                lcd_data_q <= rd_val[3:0];
                lcd_we_q   <= 1'b1;
                state_q    <= WAIT;
              end
            end
            OP_LCDRST: begin
              lcd_rst_q <= imm[0];
              pc_q      <= pc_inc;
            end
            default: pc_q <= pc_inc;
          endcase
        end
        WAIT: begin
          if (iLCD_response) begin
            lcd_we_q <= 1'b0;
            pc_q     <= pc_inc;
            state_q  <= EXEC;
          end
        end
        default: state_q <= EXEC;
      endcase
    end
  end

  assign oLed         = led_q;
  assign oLCD_data    = lcd_data_q;
  assign oLCD_reset   = lcd_rst_q;
  assign oLCD_writeEN = lcd_we_q;

endmodule

// File: tb/tb_mini_alu.sv
// Bench for mini_alu: default-ROM and custom-ROM instances checked every cycle
// against an instruction-level interpreter, plus directed handshake/reset steps.
module tb_mini_alu;

  localparam int unsigned PC_W  = 6;
  localparam int unsigned DEPTH = 2**PC_W;

  function automatic logic [15:0] prog_a_word(input int a);
    case (a)
      0: return 16'h1205; 1: return 16'h1403; 2: return 16'h2650;
      3: return 16'h6600; 4: return 16'h9200; 5: return 16'hA000;
      6: return 16'h3850; 7: return 16'h6800; 8: return 16'h7008;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] prog_b_word(input int a);
    case (a)
      0:  return 16'h1201;  // STO R1,1
      1:  return 16'h1402;  // STO R2,2
      2:  return 16'h3650;  // SUB R3,R1,R2 -> 0xFF
      3:  return 16'h6600;  // LED R3
      4:  return 16'h8286;  // BLE R1,R2 -> 6 (taken)
      5:  return 16'h1AAA;  // STO R5,0xAA (skipped)
      6:  return 16'h8449;  // BLE R2,R1 -> 9 (not taken)
      7:  return 16'h2CD8;  // ADD R6,R3,R3
      8:  return 16'h6C00;  // LED R6
      9:  return 16'h9600;  // LCD R3
      10: return 16'h4ED0;  // AND R7,R3,R2
      11: return 16'h5FC8;  // OR R7,R7,R1
      12: return 16'h6E00;  // LED R7
      13: return 16'hA001;  // LCDRST 1
      14: return 16'hA000;  // LCDRST 0
      15: return 16'hB123;  // reserved opcode
      16: return 16'h703E;  // JMP 62
      62: return 16'h6A00;  // LED R5
      63: return 16'h0000;  // NOP, then PC wraps to 0
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [DEPTH*16-1:0] build_prog_b();
    logic [DEPTH*16-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++) v[i*16 +: 16] = prog_b_word(i);
    return v;
  endfunction

  localparam logic [DEPTH*16-1:0] PROG_B = build_prog_b();

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic       rst_a, resp_a, rst_b, resp_b;
  logic [7:0] led_a, led_b;
  logic [3:0] dat_a, dat_b;
  logic       lrst_a, lrst_b, we_a, we_b;

  mini_alu #(.PC_W(PC_W), .DATA_W(8), .USE_DEFAULT_ROM(1'b1)) dut_a (
    .Clock(Clock), .Reset(rst_a), .oLed(led_a), .iLCD_response(resp_a),
    .oLCD_data(dat_a), .oLCD_reset(lrst_a), .oLCD_writeEN(we_a));

  mini_alu #(.PC_W(PC_W), .DATA_W(8), .USE_DEFAULT_ROM(1'b0), .ROM_IMAGE(PROG_B)) dut_b (
    .Clock(Clock), .Reset(rst_b), .oLed(led_b), .iLCD_response(resp_b),
    .oLCD_data(dat_b), .oLCD_reset(lrst_b), .oLCD_writeEN(we_b));

  typedef struct packed {
    logic [5:0]      pc;
    logic [7:0][7:0] r;
    logic [7:0]      led;
    logic [3:0]      data;
    logic            we;
    logic            lrst;
    logic            waiting;
  } mdl_t;

  mdl_t ma, mb;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Architectural interpreter: one call = one clock edge.
  function automatic mdl_t step(input mdl_t m, input bit use_b, input logic rst, input logic resp);
    mdl_t n;
    logic [15:0] ins;
    int op, d, a, b, imm, tgt, nxt;
    n = m;
    if (!rst) begin
      n = '0;
      n.lrst = 1'b1;
      return n;
    end
    nxt = (int'(m.pc) + 1) % DEPTH;
    if (m.waiting) begin
      if (resp) begin
        n.we = 1'b0;
        n.waiting = 1'b0;
        n.pc = 6'(nxt);
      end
      return n;
    end
    ins = use_b ? prog_b_word(int'(m.pc)) : prog_a_word(int'(m.pc));
    op  = int'(ins) / 4096;
    d   = (int'(ins) / 512) % 8;
    a   = (int'(ins) / 64) % 8;
    b   = (int'(ins) / 8) % 8;
    imm = int'(ins) % 256;
    tgt = int'(ins) % DEPTH;
    n.pc = 6'(nxt);
    case (op)
      1: n.r[d] = 8'(imm);
      2: n.r[d] = 8'((int'(m.r[a]) + int'(m.r[b])) % 256);
      3: n.r[d] = 8'((int'(m.r[a]) - int'(m.r[b]) + 256) % 256);
      4: n.r[d] = m.r[a] & m.r[b];
      5: n.r[d] = m.r[a] | m.r[b];
      6: n.led  = m.r[d];
      7: n.pc   = 6'(tgt);
      8: n.pc   = (int'(m.r[d]) <= int'(m.r[a])) ? 6'(tgt) : 6'(nxt);
      9: begin
        n.pc = m.pc;
        if (!resp) begin
          n.data = m.r[d][3:0];
          n.we = 1'b1;
          n.waiting = 1'b1;
        end
      end
      10: n.lrst = imm[0];
      default: ;
    endcase
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic ra, input logic pa, input logic rb, input logic pb);
    rst_a = ra; resp_a = pa; rst_b = rb; resp_b = pb;
    ma = step(ma, 1'b0, ra, pa);
    mb = step(mb, 1'b1, rb, pb);
    @(posedge Clock);
    #1;
    chk("A.pc",   32'(dut_a.pc_q), 32'(ma.pc));
    chk("A.led",  32'(led_a),      32'(ma.led));
    chk("A.data", 32'(dat_a),      32'(ma.data));
    chk("A.we",   32'(we_a),       32'(ma.we));
    chk("A.lrst", 32'(lrst_a),     32'(ma.lrst));
    chk("B.pc",   32'(dut_b.pc_q), 32'(mb.pc));
    chk("B.led",  32'(led_b),      32'(mb.led));
    chk("B.data", 32'(dat_b),      32'(mb.data));
    chk("B.we",   32'(we_b),       32'(mb.we));
    chk("B.lrst", 32'(lrst_b),     32'(mb.lrst));
  endtask

  initial begin
    ma = '0; mb = '0;
    rst_a = 1'b0; resp_a = 1'b0; rst_b = 1'b0; resp_b = 1'b0;

    // Reset held five cycles on both instances
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.pc",   32'(dut_a.pc_q), 32'd0);
    chk("rst.led",  32'(led_a),      32'h00);
    chk("rst.we",   32'(we_a),       32'd0);
    chk("rst.lrst", 32'(lrst_a),     32'd1);
    chk("rst.data", 32'(dat_a),      32'd0);

    // Default program, no LCD ack
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rel.pc1", 32'(dut_a.pc_q), 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("add.led", 32'(led_a), 32'h08);
    chk("add.pc",  32'(dut_a.pc_q), 32'd4);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("lcd.we",   32'(we_a),        32'd1);
      chk("lcd.data", 32'(dat_a),       32'h5);
      chk("lcd.pc",   32'(dut_a.pc_q),  32'd4);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("ack.we", 32'(we_a),       32'd0);
    chk("ack.pc", 32'(dut_a.pc_q), 32'd5);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("lcdrst.lrst", 32'(lrst_a), 32'd0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'(i % 2), 1'b0, 1'b0);
      chk("run.we", 32'(we_a), 32'd0);
    end
    chk("halt.led", 32'(led_a),      32'h02);
    chk("halt.pc",  32'(dut_a.pc_q), 32'd8);

    // Busy controller: stall, then send, then reset during WAIT
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("stall.pc", 32'(dut_a.pc_q), 32'd4);
    chk("stall.we", 32'(we_a),       32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("send.we",  32'(we_a), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("hold.we",  32'(we_a), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrst.we",  32'(we_a),       32'd0);
    chk("wrst.pc",  32'(dut_a.pc_q), 32'd0);

    // Custom program: SUB wrap and both BLE outcomes
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("wrap.led", 32'(led_b),      32'hFF);
    chk("wrap.pc",  32'(dut_b.pc_q), 32'd4);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ble.taken", 32'(dut_b.pc_q), 32'd6);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ble.fall",  32'(dut_b.pc_q), 32'd7);

    // Randomised responses and occasional resets on both instances
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 79) != 0), ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
